multicycle_control_fsm: RTL and testbench

//  Sequencing controller for the multicycle variant of the MIPS datapath. Walks each instruction through

---
 rtl/multicycle_control_fsm.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: per-cycle datapath strobes,
// memory wait/timeout handling and irq/exception entry at instruction end.
module multicycle_control_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ker,
  input  logic       irq,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic [2:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] memtoreg,
  output logic       alu_src1,
  output logic [1:0] alu_src2,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    BOOT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    MEMADR = 4'd4,
    MEMACC = 4'd5,
    WB     = 4'd6,
    BRANCH = 4'd7,
    JUMP   = 4'd8,
    IRQ    = 4'd9,
    EXC    = 4'd10
  } st_t;

  localparam logic [CNT_W-1:0] WMAX  = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(WAIT_MAX - 1);

  st_t              cur;
  st_t              nxt;
  st_t              eoi;
  logic [CNT_W-1:0] wcnt;

  logic rtype;
  logic legal;
  logic is_jump;
  logic is_branch;
  logic is_mem;
  logic is_sw;
  logic timeout;

  assign rtype = (opcode == 6'h00);
  assign legal = rtype
    ? (funct inside {6'h00, 6'h02, 6'h03, 6'h08,
                     6'h09, [6'h20:6'h27], 6'h2a})
    : (opcode inside {[6'h01:6'h0c], 6'h0f,
                      6'h23, 6'h2b});
  assign is_jump = (opcode == 6'h02) || (opcode == 6'h03)
    || (rtype && (funct inside {6'h08, 6'h09}));
  assign is_branch = opcode inside {6'h01, [6'h04:6'h07]};
  assign is_mem = (opcode == 6'h23) || (opcode == 6'h2b);
  assign is_sw = (opcode == 6'h2b);
  // 15th consecutive wait cycle is the last one tolerated
  assign timeout = !mem_ready && (wcnt == WLAST);
  assign eoi = (irq && !ker) ? IRQ : FETCH;
  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= BOOT;
    else       cur <= nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wcnt <= '0;
    else if (nxt != cur && (nxt == FETCH || nxt == MEMACC))
      wcnt <= '0;
    else if ((cur == FETCH || cur == MEMACC) && !mem_ready
             && wcnt != WMAX)
      wcnt <= wcnt + CNT_W'(1);
  end

  always_comb begin
    nxt = EXC;
    case (cur)
      BOOT:   nxt = FETCH;
      FETCH:  nxt = mem_ready ? DECODE : (timeout ? EXC : FETCH);
      DECODE: begin
        if (!legal)         nxt = EXC;
        else if (is_jump)   nxt = JUMP;
        else if (is_branch) nxt = BRANCH;
        else if (is_mem)    nxt = MEMADR;
        else                nxt = EXEC;
      end
      EXEC:   nxt = WB;
      MEMADR: nxt = MEMACC;
      MEMACC: begin
        if (mem_ready)    nxt = is_sw ? eoi : WB;
        else if (timeout) nxt = EXC;
        else              nxt = MEMACC;
      end
      WB, BRANCH, JUMP: nxt = eoi;
      IRQ, EXC:         nxt = FETCH;
      default:          nxt = EXC;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 3'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    memtoreg   = 2'd0;
    alu_src1   = 1'b0;
    alu_src2   = 2'd0;
    alu_op     = 2'd0;
    instr_done = 1'b0;
    case (cur)
      FETCH: begin
        mem_read = 1'b1;
        alu_src2 = 2'd1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: alu_src2 = 2'd3;
      EXEC: begin
        alu_op   = 2'd2;
        alu_src1 = 1'b1;
        alu_src2 = rtype ? 2'd0 : 2'd2;
      end
      MEMADR: begin
        alu_src1 = 1'b1;
        alu_src2 = 2'd2;
      end
      MEMACC: begin
        iord       = 1'b1;
        mem_read   = !is_sw;
        mem_write  = is_sw;
        instr_done = is_sw && mem_ready;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = rtype ? 2'd0 : 2'd1;
        memtoreg   = (opcode == 6'h23) ? 2'd1 : 2'd0;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_op     = 2'd1;
        pc_src     = 3'd1;
        pc_write   = branch_taken;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        pc_src     = rtype ? 3'd3 : 3'd2;
        if (opcode == 6'h03) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          memtoreg  = 2'd2;
        end else if (rtype && funct == 6'h09) begin
          reg_write = 1'b1;
          memtoreg  = 2'd2;
        end
      end
      IRQ, EXC: begin
        pc_write   = 1'b1;
        pc_src     = (cur == IRQ) ? 3'd4 : 3'd5;
        reg_write  = 1'b1;
        reg_dst    = 2'd3;
        memtoreg   = 2'd2;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// and compares the full strobe vector against hand-computed values.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ker;
  logic       irq;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_write;
  logic [2:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] memtoreg;
  logic       alu_src1;
  logic [1:0] alu_src2;
  logic [1:0] alu_op;
  logic       instr_done;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  logic [22:0] obs;
  logic [22:0] e;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .ker(ker), .irq(irq), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .memtoreg(memtoreg), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_op(alu_op),
    .instr_done(instr_done), .state(state)
  );

  assign obs = {state, pc_write, pc_src, ir_write, iord, mem_read,
                mem_write, reg_write, reg_dst, memtoreg, alu_src1,
                alu_src2, alu_op, instr_done};

  // order: st pcw pcs irw iord mr mw rw rd m2r a1 a2 aop done
  function automatic logic [22:0] pk(
    input logic [3:0] st, input logic pcw, input logic [2:0] pcs,
    input logic irw, input logic io, input logic mr, input logic mw,
    input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
    input logic a1, input logic [1:0] a2, input logic [1:0] aop,
    input logic dn);
    return {st, pcw, pcs, irw, io, mr, mw, rw, rd, m2r, a1, a2, aop, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; ker = 1'b0;
    irq = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== e) begin bad++; $display("FAIL boot got=%h exp=%h", obs, e); end
  endtask

  task automatic test_addu();
    int dn;
    dn = 0;
    opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1;
    step();
    dn += int'(instr_done);
    e = pk(1,1,0,1,0,1,0,0,0,0,0,1,0,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL addu_fetch got=%h exp=%h", obs, e); end
    step();
    dn += int'(instr_done);
    e = pk(2,0,0,0,0,0,0,0,0,0,0,3,0,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL addu_decode got=%h exp=%h", obs, e); end
    step();
    dn += int'(instr_done);
    e = pk(3,0,0,0,0,0,0,0,0,0,1,0,2,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL addu_exec got=%h exp=%h", obs, e); end
    step();
    dn += int'(instr_done);
    e = pk(6,0,0,0,0,0,0,1,0,0,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL addu_wb got=%h exp=%h", obs, e); end
    step();
    dn += int'(instr_done);
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL addu_refetch got=%0d exp=1", state); end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL addu_done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_lw();
    int acc;
    acc = 0;
    opcode = 6'h23;
    step();
    step();
    e = pk(4,0,0,0,0,0,0,0,0,0,1,2,0,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL lw_memadr got=%h exp=%h", obs, e); end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) begin mem_ready = 1'b1; #1; end
      if (state == 4'd5 && iord && mem_read && !mem_write) acc++;
    end
    total++;
    if (acc !== 4) begin bad++; $display("FAIL lw_memacc_cycles got=%0d exp=4", acc); end
    step();
    e = pk(6,0,0,0,0,0,0,1,1,1,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL lw_wb got=%h exp=%h", obs, e); end
    step();
  endtask

  task automatic test_branch();
    opcode = 6'h04; branch_taken = 1'b0;
    step();
    step();
    e = pk(7,0,1,0,0,0,0,0,0,0,0,0,1,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL beq_nt got=%h exp=%h", obs, e); end
    step();
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL beq_nt_ret got=%0d exp=1", state); end
    step();
    step();
    branch_taken = 1'b1;
    #1;
    e = pk(7,1,1,0,0,0,0,0,0,0,0,0,1,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL beq_t got=%h exp=%h", obs, e); end
    step();
    branch_taken = 1'b0;
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL beq_t_ret got=%0d exp=1", state); end
  endtask

  task automatic test_irq();
    opcode = 6'h00; funct = 6'h20;
    step();
    step();
    irq = 1'b1; ker = 1'b0;
    step();
    total++;
    if (state !== 4'd6) begin bad++; $display("FAIL irq_wb got=%0d exp=6", state); end
    step();
    e = pk(9,1,4,0,0,0,0,1,3,2,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL irq_entry got=%h exp=%h", obs, e); end
    step();
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL irq_ret got=%0d exp=1", state); end
    ker = 1'b1;
    repeat (4) step();
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL irq_masked got=%0d exp=1", state); end
    irq = 1'b0; ker = 1'b0;
  endtask

  task automatic test_illegal_jump();
    opcode = 6'h3f;
    step();
    step();
    e = pk(10,1,5,0,0,0,0,1,3,2,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL illegal_exc got=%h exp=%h", obs, e); end
    step();
    opcode = 6'h03;
    step();
    step();
    e = pk(8,1,2,0,0,0,0,1,2,2,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL jal got=%h exp=%h", obs, e); end
    step();
    opcode = 6'h00; funct = 6'h08;
    step();
    step();
    e = pk(8,1,3,0,0,0,0,0,0,0,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL jr got=%h exp=%h", obs, e); end
    step();
  endtask

  task automatic test_timeout();
    int inf;
    inf = 0;
    opcode = 6'h00; funct = 6'h21; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (state == 4'd1) inf++;
      step();
    end
    total++;
    if (inf !== 15) begin bad++; $display("FAIL timeout_waits got=%0d exp=15", inf); end
    total++;
    if (state !== 4'd10) begin bad++; $display("FAIL timeout_exc got=%0d exp=10", state); end
    step();
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1;
    step();
    total++;
    if (state !== 4'd2) begin bad++; $display("FAIL ready_wins got=%0d exp=2", state); end
    repeat (3) step();
  endtask

  task automatic test_sw_reset();
    opcode = 6'h2b;
    step();
    step();
    step();
    e = pk(5,0,0,0,1,0,1,0,0,0,0,0,0,1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL sw_done got=%h exp=%h", obs, e); end
    step();
    step();
    step();
    mem_ready = 1'b0;
    step();
    e = pk(5,0,0,0,1,0,1,0,0,0,0,0,0,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL sw_wait got=%h exp=%h", obs, e); end
    reset = 1'b1;
    #1;
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL sw_async_reset got=%h exp=%h", obs, e); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_branch();
    test_irq();
    test_illegal_jump();
    test_timeout();
    test_sw_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
